// File: rtl/dec2to4_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input handshake.
// Each accepted code produces a HOLD-cycle one-hot pulse followed by a one-cycle gap.
module dec2to4_seq #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      sel,
  output logic                  in_ready,
  output logic [2**WIDTH-1:0]   y,
  output logic                  out_valid,
  output logic                  busy,
  output logic [CNT_W-1:0]      count
);

  localparam int OUT_W = 2**WIDTH;
  localparam int HC_W  = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   sel_r, sel_s;
  logic [HC_W-1:0]    hold_cnt_r, hold_cnt_s;
  logic [OUT_W-1:0]   y_s;
  logic               out_valid_s;
  logic               busy_s;
  logic [CNT_W-1:0]   count_s;

  function automatic logic [OUT_W-1:0] onehot(input logic [WIDTH-1:0] code);
    logic [OUT_W-1:0] base;
    base   = {{(OUT_W-1){1'b0}}, 1'b1};
    onehot = base << code;
  endfunction

  assign in_ready = (state_r == S_IDLE) && en;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      sel_r      <= {WIDTH{1'b0}};
      hold_cnt_r <= {HC_W{1'b0}};
      y          <= {OUT_W{1'b0}};
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      count      <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      hold_cnt_r <= hold_cnt_s;
      y          <= y_s;
      out_valid  <= out_valid_s;
      busy       <= busy_s;
      count      <= count_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    hold_cnt_s  = hold_cnt_r;
    y_s         = {OUT_W{1'b0}};
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    count_s     = count;
    case (state_r)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          sel_s       = sel;
          y_s         = onehot(sel);
          out_valid_s = 1'b1;
          busy_s      = 1'b1;
          hold_cnt_s  = HC_W'(HOLD - 1);
          state_s     = S_HOLD;
          if (count != {CNT_W{1'b1}}) begin
            count_s = count + CNT_W'(1);
          end else begin
            count_s = count;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HOLD: begin
        busy_s = 1'b1;
        // An enable drop aborts the pulse the same way the final hold cycle ends it.
        if (!en || (hold_cnt_r == {HC_W{1'b0}})) begin
          state_s = S_GAP;
        end else begin
          hold_cnt_s  = hold_cnt_r - HC_W'(1);
          y_s         = onehot(sel_r);
          out_valid_s = 1'b1;
        end
      end
      S_GAP: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dec2to4_seq.sv
// Directed self-checking bench for dec2to4_seq (WIDTH=2, HOLD=4, CNT_W=8).
module tb_dec2to4_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [1:0] sel;
  logic       in_ready;
  logic [3:0] y;
  logic       out_valid;
  logic       busy;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [1:0] code;
    logic [3:0] exp_y;
  } vec_t;

  vec_t vecs [4];

  dec2to4_seq #(.WIDTH(2), .HOLD(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sel(sel),
    .in_ready(in_ready), .y(y), .out_valid(out_valid), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one code from IDLE and check the full HOLD + GAP pulse shape.
  task automatic send_and_check(input logic [1:0] s, input logic [3:0] ey);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    sel      = s;
    step();
    in_valid = 1'b0;
    if (exp_cnt != 255) exp_cnt++;
    check("count", {24'd0, count}, exp_cnt);
    for (int i = 0; i < 4; i++) begin
      check("y_hold", {28'd0, y}, {28'd0, ey});
      check("out_valid_hold", {31'd0, out_valid}, 32'd1);
      check("busy_hold", {31'd0, busy}, 32'd1);
      check("in_ready_hold", {31'd0, in_ready}, 32'd0);
      if (i == 1) sel = ~s;
      step();
    end
    check("y_gap", {28'd0, y}, 32'd0);
    check("out_valid_gap", {31'd0, out_valid}, 32'd0);
    check("busy_gap", {31'd0, busy}, 32'd1);
    check("in_ready_gap", {31'd0, in_ready}, 32'd0);
    step();
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{code: 2'd0, exp_y: 4'b0001};
    vecs[1] = '{code: 2'd1, exp_y: 4'b0010};
    vecs[2] = '{code: 2'd2, exp_y: 4'b0100};
    vecs[3] = '{code: 2'd3, exp_y: 4'b1000};

    rst = 1'b0; en = 1'b1; in_valid = 1'b0; sel = 2'd0;

    // Reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_y", {28'd0, y}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {24'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All four codes, back to back
    for (int v = 0; v < 4; v++) begin
      send_and_check(vecs[v].code, vecs[v].exp_y);
    end
    check("count_after_codes", {24'd0, count}, 32'd4);

    // Continuous in_valid with sel=2; sel=3 during HOLD must not show
    in_valid = 1'b1;
    sel      = 2'd2;
    step();
    for (int k = 0; k < 18; k++) begin
      check("bp_y", {28'd0, y}, ((k % 6) < 4) ? 32'h4 : 32'h0);
      check("bp_out_valid", {31'd0, out_valid}, ((k % 6) < 4) ? 32'd1 : 32'd0);
      sel = ((k % 6) >= 1 && (k % 6) <= 3) ? 2'd3 : 2'd2;
      if (k == 17) in_valid = 1'b0;
      step();
    end
    exp_cnt += 3;
    check("bp_count", {24'd0, count}, exp_cnt);

    // Enable abort after two HOLD cycles
    check("ab_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    sel      = 2'd1;
    step();
    in_valid = 1'b0;
    exp_cnt++;
    check("ab_y0", {28'd0, y}, 32'h2);
    step();
    check("ab_y1", {28'd0, y}, 32'h2);
    en = 1'b0;
    step();
    check("ab_y_gap", {28'd0, y}, 32'h0);
    check("ab_out_valid_gap", {31'd0, out_valid}, 32'd0);
    check("ab_busy_gap", {31'd0, busy}, 32'd1);
    step();
    check("ab_busy_idle", {31'd0, busy}, 32'd0);
    check("ab_in_ready_en0", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    sel      = 2'd3;
    step();
    in_valid = 1'b0;
    check("ab_drop_y", {28'd0, y}, 32'h0);
    check("ab_drop_count", {24'd0, count}, exp_cnt);
    check("ab_in_ready_still0", {31'd0, in_ready}, 32'd0);
    en = 1'b1;
    #1;
    check("ab_in_ready_en1", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset in the second HOLD cycle
    in_valid = 1'b1;
    sel      = 2'd3;
    step();
    in_valid = 1'b0;
    check("ar_y_before", {28'd0, y}, 32'h8);
    step();
    #2 rst = 1'b1;
    #1;
    check("ar_y", {28'd0, y}, 32'h0);
    check("ar_count", {24'd0, count}, 32'd0);
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    send_and_check(2'd0, 4'b0001);
    check("ar_count_after", {24'd0, count}, 32'd1);

    // Saturation: 260 more accepts
    for (int n = 0; n < 260; n++) begin
      send_and_check(vecs[n % 4].code, vecs[n % 4].exp_y);
    end
    check("sat_count", {24'd0, count}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
